alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU. Adds RV32M/RV64M multiply, divide and remainder.
- Operands enter through a valid/ready handshake. Base ops complete in 1 cycle. Mul/div ops iterate one bit per cycle.
- Sits between decode/register-read and writeback. The core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  unit can accept; high only in IDLE
- a  in  WIDTH  operand A (signed interpretation where op requires)
- b  in  WIDTH  operand B
- op  in  5  operation code, alu_op_e
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- illegal  out  1  op was not a defined code; valid with out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0, counter=0. Any in-flight op is abandoned; nothing is output after release.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRA, 9 SRL.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18–31 illegal.
- Shifts use b[SHW-1:0] only. Upper bits of b are ignored.
- SLT/SLTU produce a zero-extended 1-bit result.
- Handshake: accept when in_valid && in_ready. Operands and op are captured on that edge; a/b may then change freely.
- States IDLE, CALC, DONE:
  - IDLE, accept base or illegal op -> DONE next edge. Result computed combinationally and registered, so latency is 1 (out_valid high the cycle after accept). Illegal op: result=0, illegal=1.
  - IDLE, accept mul op -> CALC with counter=WIDTH.
  - IDLE, accept div/rem op, normal case -> CALC with counter=WIDTH.
  - IDLE, accept div/rem op, special case -> DONE directly with latency 1:
    - Divide by zero: DIV/DIVU give all-ones, REM/REMU give a.
    - Signed overflow (a = most negative, b = -1): DIV gives a, REM gives 0.
  - CALC: one iteration per cycle, counter decrements. At counter==1 the final sign fix-up is applied -> DONE. Total latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1; result/zero/illegal held stable until out_ready. When out_valid && out_ready -> IDLE. No new accept in the same cycle; in_ready rises the following cycle.
- Multiply: shift-add on |a|,|b| magnitudes into a 2*WIDTH product, sign applied at end.
  - MUL returns the low half. MULH/MULHSU/MULHU return the high half.
  - MULHSU treats a as signed, b as unsigned.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of a.
- in_valid during CALC/DONE is ignored (in_ready=0); the producer must hold its inputs.
- out_ready while not in DONE has no effect.
- zero reflects the registered result only.

Decomposition:
- alu_pkg:
  - typedef enum logic[4:0] alu_op_e (codes above).
  - typedef enum logic[1:0] state_e {IDLE, CALC, DONE}.
  - Helper functions is_mul(op), is_div(op).
- One sub-module, muldiv_iter: the iterative datapath holding the product/remainder register, counter and sign flags. It exposes start/done and the final word.
- alu_iter owns the FSM, the base-op combinational logic and the output registers.

Test Plan (WIDTH=32):
- ADD a=7FFFFFFF b=1 -> one cycle later out_valid=1, result=80000000, zero=0. SUB a=5 b=5 -> result=0, zero=1.
- SRA a=80000000 b=00000024 (uses b[4:0]=4) -> result=F8000000. SLTU a=FFFFFFFF b=1 -> 0. SLT same operands -> 1.
- MULH a=FFFFFFFF(-1) b=FFFFFFFF(-1) -> after 33 cycles result=0. MULHU same operands -> FFFFFFFE. MUL -> 1.
- DIV a=FFFFFFF9(-7) b=2 -> FFFFFFFD(-3); REM -> FFFFFFFF(-1), latency 33. DIVU a=64 b=0 -> FFFFFFFF at latency 1. DIV a=80000000 b=FFFFFFFF -> 80000000. REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL completes -> result stable, in_ready=0 throughout. Pulse out_ready -> IDLE, in_ready=1 the next cycle.
- Reset mid-CALC (DIVU, counter=10): drop rst_n -> out_valid=0 and state IDLE immediately. After release, no stale result; a fresh ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and op-class helpers for the iterative ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRA    = 5'd8,
    OP_SRL    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_LEGAL_OP = 5'd17;

  function automatic logic is_mul(input logic [4:0] op);
    return (op >= 5'd10) && (op <= 5'd13);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= 5'd14) && (op <= 5'd17);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return op <= LAST_LEGAL_OP;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply/divide datapath: one bit per cycle on operand
// magnitudes, with the sign fix-up folded into the last iteration.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] word
);

  localparam int CW = $clog2(WIDTH) + 1;

  // acc holds {high, low} of the product, or {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               neg_r;
  logic [4:0]         op_q;

  logic               a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_cand;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  // Operand sign handling at start
  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    sa    = a_signed & a[WIDTH-1];
    sb    = b_signed & b[WIDTH-1];
    mag_a = sa ? (~a + 1'b1) : a;
    mag_b = sb ? (~b + 1'b1) : b;
  end

  // One shift-add or restoring-divide step, plus the final sign fix-up
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    div_cand = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = div_cand >= {1'b0, opnd};
    div_rem  = div_ge ? (div_cand - {1'b0, opnd}) : div_cand;
    div_next = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

    acc_next = is_mul(op_q) ? mul_next : div_next;

    prod_fix = neg_q ? (~mul_next + 1'b1) : mul_next;
    quo      = div_next[WIDTH-1:0];
    rem      = div_next[2*WIDTH-1:WIDTH];

    word = '0;
    case (op_q)
      OP_MUL:                      word = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: word = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             word = neg_q ? (~quo + 1'b1) : quo;
      OP_REM, OP_REMU:             word = neg_r ? (~rem + 1'b1) : rem;
      default:                     word = '0;
    endcase

    done = (cnt == CW'(1));
  end

  // Load on start, then iterate while the counter is non-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      op_q  <= '0;
    end else if (start) begin
      op_q  <= op;
      cnt   <= CW'(WIDTH);
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (is_mul(op)) begin
        acc  <= {{WIDTH{1'b0}}, mag_b};
        opnd <= mag_a;
      end else begin
        acc  <= {{WIDTH{1'b0}}, mag_a};
        opnd <= mag_b;
      end
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle base ops, iterative mul/div/rem,
// valid/ready on both sides with the result held until consumed.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state, state_next;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_word;
  logic             load_direct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res, spec_res, direct_res;
  logic             div_zero, div_ovf, div_special;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .word  (md_word)
  );

  // Single-cycle results: base ops and the div/rem short-cuts
  always_comb begin
    shamt    = b[SHW-1:0];
    base_res = '0;
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  base_res = a << shamt;
      OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
      OP_SRL:  base_res = a >> shamt;
      default: base_res = '0;
    endcase

    div_zero = (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    div_special = is_div(op) && (div_zero || div_ovf);

    spec_res = '0;
    if (div_zero)
      spec_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    else if (div_ovf)
      spec_res = (op == OP_DIV) ? a : '0;

    if (!is_legal(op))
      direct_res = '0;
    else if (is_div(op))
      direct_res = spec_res;
    else
      direct_res = base_res;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake controls
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    md_start    = 1'b0;
    load_direct = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_mul(op) || (is_div(op) && !div_special)) begin
            md_start   = 1'b1;
            state_next = CALC;
          end else begin
            load_direct = 1'b1;
            state_next  = DONE;
          end
        end
      end
      CALC: if (md_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Output registers, written once per operation and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (load_direct) begin
      result  <= direct_res;
      zero    <= (direct_res == '0);
      illegal <= !is_legal(op);
    end else if ((state == CALC) && md_done) begin
      result  <= md_word;
      zero    <= (md_word == '0);
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed, table-driven bench for alu_iter at WIDTH=32.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [4:0]  op;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, illegal, busy;

  int checks = 0;
  int errors = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one op, wait for out_valid; returns cycles from accept to out_valid
  task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;

    //          op     a             b             result        z  ill lat
    vecs.push_back('{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1});
    vecs.push_back('{5'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1});
    vecs.push_back('{5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 1});
    vecs.push_back('{5'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F, 0, 0, 1});
    vecs.push_back('{5'd4,  32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 0, 0, 1});
    vecs.push_back('{5'd8,  32'h80000000, 32'h00000024, 32'hF8000000, 0, 0, 1});
    vecs.push_back('{5'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1});
    vecs.push_back('{5'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 1});
    vecs.push_back('{5'd7,  32'h00000001, 32'h00000021, 32'h00000002, 0, 0, 1});
    vecs.push_back('{5'd9,  32'h80000000, 32'h0000001F, 32'h00000001, 0, 0, 1});
    vecs.push_back('{5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 33});
    vecs.push_back('{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 33});
    vecs.push_back('{5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33});
    vecs.push_back('{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 33});
    vecs.push_back('{5'd10, 32'h00000006, 32'hFFFFFFF9, 32'hFFFFFFD6, 0, 0, 33});
    vecs.push_back('{5'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 0, 33});
    vecs.push_back('{5'd16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 0, 33});
    vecs.push_back('{5'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 33});
    vecs.push_back('{5'd16, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 0, 0, 33});
    vecs.push_back('{5'd15, 32'h00000064, 32'h00000007, 32'h0000000E, 0, 0, 33});
    vecs.push_back('{5'd17, 32'h00000064, 32'h00000007, 32'h00000002, 0, 0, 33});
    vecs.push_back('{5'd15, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1});
    vecs.push_back('{5'd14, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1});
    vecs.push_back('{5'd17, 32'h00000064, 32'h00000000, 32'h00000064, 0, 0, 1});
    vecs.push_back('{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1});
    vecs.push_back('{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1});
    vecs.push_back('{5'd18, 32'h12345678, 32'h00000001, 32'h00000000, 1, 1, 1});
    vecs.push_back('{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1, 1});

    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result",    {32'd0, result},    64'd0);
    chk("rst_zero",      {63'd0, zero},      64'd0);
    chk("rst_illegal",   {63'd0, illegal},   64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_result", i),  {32'd0, result},  {32'd0, vecs[i].res});
      chk($sformatf("v%0d_zero", i),    {63'd0, zero},    {63'd0, vecs[i].zero});
      chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].ill});
      chk($sformatf("v%0d_latency", i), 64'(lat),         64'(vecs[i].lat));
      consume();
    end

    // Backpressure: result held for 5 cycles, then single accept
    do_op(5'd10, 32'd6, 32'd7, lat);
    chk("bp_latency", 64'(lat), 64'd33);
    chk("bp_result0", {32'd0, result}, 64'd42);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", k),   {32'd0, result},    64'd42);
      chk($sformatf("bp_hold%0d_valid", k),    {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_hold%0d_in_ready", k), {63'd0, in_ready},  64'd0);
    end
    consume();
    @(negedge clk);
    chk("bp_after_in_ready",  {63'd0, in_ready},  64'd1);
    chk("bp_after_out_valid", {63'd0, out_valid}, 64'd0);

    // Reset while the divider is at counter 10
    @(negedge clk);
    op = 5'd15; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (23) @(negedge clk);
    chk("mid_busy",      {63'd0, busy},      64'd1);
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_busy",      {63'd0, busy},      64'd0);
    chk("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    chk("no_stale_output", {63'd0, seen_valid}, 64'd0);
    do_op(5'd0, 32'd2, 32'd3, lat);
    chk("post_rst_add", {32'd0, result}, 64'd5);
    chk("post_rst_lat", 64'(lat), 64'd1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
